// File: rtl/time_pkg.sv
// Shared definitions for the time-setting controller and the timekeeping counter.
package time_pkg;

   localparam int HOUR_W       = 5;
   localparam int MS_W         = 6;
   localparam int HOUR_MAX_DEF = 23;
   localparam int MS_MAX_DEF   = 59;
   localparam int TIMEOUT_DEF  = 30;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SET_H  = 3'd1,
      ST_SET_M  = 3'd2,
      ST_SET_S  = 3'd3,
      ST_COMMIT = 3'd4
   } state_t;

   localparam logic [1:0] FIELD_NONE = 2'b00;
   localparam logic [1:0] FIELD_HOUR = 2'b01;
   localparam logic [1:0] FIELD_MIN  = 2'b10;
   localparam logic [1:0] FIELD_SEC  = 2'b11;

   // Display blink code for the field being edited in a given state.
   function automatic logic [1:0] field_of(input state_t st);
      case (st)
         ST_SET_H: return FIELD_HOUR;
         ST_SET_M: return FIELD_MIN;
         ST_SET_S: return FIELD_SEC;
         default:  return FIELD_NONE;
      endcase
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_edge.sv
// Two-flop synchronizer with rising-edge detect for one asynchronous button.
// A button already held when reset releases must first be seen released before
// it can produce an event, so a held key never fires spuriously after reset.
module btn_edge (
   input  logic slowclk,
   input  logic reset,
   input  logic btn,
   output logic evt
);

   logic       sync1;
   logic       sync2;
   logic       prev;
   logic       armed;
   logic [1:0] vld;

   // Synchronize, remember the previous level, and arm once a genuine low is seen.
   always_ff @(posedge slowclk or negedge reset) begin
      if (!reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
         armed <= 1'b0;
         vld   <= 2'b00;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
         vld   <= {vld[0], 1'b1};
         armed <= armed | (vld[1] & ~sync2);
      end
   end

   assign evt = sync2 & ~prev & armed;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller feeding the clock's load interface.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | not editing; edit registers hold their last values
//   ST_SET_H  | editing hours (seeded from running time on entry)
//   ST_SET_M  | editing minutes
//   ST_SET_S  | editing seconds
//   ST_COMMIT | one-cycle load strobe with the edited time, then IDLE
module time_set_ctrl
   import time_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
   parameter int HOUR_MAX       = HOUR_MAX_DEF,
   parameter int MS_MAX         = MS_MAX_DEF
) (
   input  logic              slowclk,
   input  logic              reset,
   input  logic              btn_mode,
   input  logic              btn_inc,
   input  logic              btn_dec,
   input  logic [HOUR_W-1:0] cur_h,
   input  logic [MS_W-1:0]   cur_m,
   input  logic [MS_W-1:0]   cur_s,
   output logic [HOUR_W-1:0] h_set,
   output logic [MS_W-1:0]   m_set,
   output logic [MS_W-1:0]   s_set,
   output logic              load,
   output logic [1:0]        field,
   output logic              busy
);

   // Inactivity timer counts down from TIMEOUT_CYCLES-1; expiry is seen at zero.
   localparam int                TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0]  TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [HOUR_W-1:0] H_MAX    = HOUR_W'(HOUR_MAX);
   localparam logic [MS_W-1:0]   T_MAX    = MS_W'(MS_MAX);

   state_t            state;
   state_t            state_nxt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic [TMO_W-1:0]  tmo_nxt;
   logic [HOUR_W-1:0] h_nxt;
   logic [MS_W-1:0]   m_nxt;
   logic [MS_W-1:0]   s_nxt;

   logic ev_mode;
   logic ev_inc;
   logic ev_dec;
   logic step_up;
   logic step_dn;

   logic [HOUR_W-1:0] h_up;
   logic [HOUR_W-1:0] h_dn;
   logic [MS_W-1:0]   m_up;
   logic [MS_W-1:0]   m_dn;
   logic [MS_W-1:0]   s_up;
   logic [MS_W-1:0]   s_dn;

   btn_edge u_mode (.slowclk(slowclk), .reset(reset), .btn(btn_mode), .evt(ev_mode));
   btn_edge u_inc  (.slowclk(slowclk), .reset(reset), .btn(btn_inc),  .evt(ev_inc));
   btn_edge u_dec  (.slowclk(slowclk), .reset(reset), .btn(btn_dec),  .evt(ev_dec));

   // inc and dec together cancel; an out-of-range seed steps up to 0 or down by one.
   assign step_up = ev_inc & ~ev_dec;
   assign step_dn = ev_dec & ~ev_inc;

   assign h_up = (h_set >= H_MAX) ? '0 : h_set + 5'd1;
   assign h_dn = (h_set == '0) ? H_MAX : h_set - 5'd1;
   assign m_up = (m_set >= T_MAX) ? '0 : m_set + 6'd1;
   assign m_dn = (m_set == '0) ? T_MAX : m_set - 6'd1;
   assign s_up = (s_set >= T_MAX) ? '0 : s_set + 6'd1;
   assign s_dn = (s_set == '0) ? T_MAX : s_set - 6'd1;

   // State, edit registers and inactivity timer.
   always_ff @(posedge slowclk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         h_set   <= '0;
         m_set   <= '0;
         s_set   <= '0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_nxt;
         h_set   <= h_nxt;
         m_set   <= m_nxt;
         s_set   <= s_nxt;
         tmo_cnt <= tmo_nxt;
      end
   end

   // Next-state, edit-field stepping and decoded outputs; mode outranks inc/dec.
   always_comb begin
      state_nxt = state;
      h_nxt     = h_set;
      m_nxt     = m_set;
      s_nxt     = s_set;
      tmo_nxt   = tmo_cnt;
      field     = field_of(state);
      busy      = (state != ST_IDLE);
      load      = (state == ST_COMMIT);

      case (state)
         ST_IDLE: begin
            tmo_nxt = '0;
            if (ev_mode) begin
               h_nxt     = cur_h;
               m_nxt     = cur_m;
               s_nxt     = cur_s;
               tmo_nxt   = TMO_LOAD;
               state_nxt = ST_SET_H;
            end
         end
         ST_SET_H, ST_SET_M, ST_SET_S: begin
            if (ev_mode) begin
               tmo_nxt = TMO_LOAD;
               case (state)
                  ST_SET_H: state_nxt = ST_SET_M;
                  ST_SET_M: state_nxt = ST_SET_S;
                  default:  state_nxt = ST_COMMIT;
               endcase
            end else if (ev_inc | ev_dec) begin
               tmo_nxt = TMO_LOAD;
               case (state)
                  ST_SET_H: begin
                     if (step_up) h_nxt = h_up;
                     if (step_dn) h_nxt = h_dn;
                  end
                  ST_SET_M: begin
                     if (step_up) m_nxt = m_up;
                     if (step_dn) m_nxt = m_dn;
                  end
                  default: begin
                     if (step_up) s_nxt = s_up;
                     if (step_dn) s_nxt = s_dn;
                  end
               endcase
            end else if (tmo_cnt == '0) begin
               state_nxt = ST_IDLE;
            end else begin
               tmo_nxt = tmo_cnt - 1'b1;
            end
         end
         ST_COMMIT: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with a cycle-level behavioural model.
module tb_time_set_ctrl;

   localparam int TIMEOUT = 30;
   localparam int HMAX    = 23;
   localparam int MSMAX   = 59;

   logic       slowclk  = 1'b0;
   logic       reset    = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc  = 1'b0;
   logic       btn_dec  = 1'b0;
   logic [4:0] cur_h    = '0;
   logic [5:0] cur_m    = '0;
   logic [5:0] cur_s    = '0;
   logic [4:0] h_set;
   logic [5:0] m_set;
   logic [5:0] s_set;
   logic       load;
   logic [1:0] field;
   logic       busy;

   int n_err    = 0;
   int n_checks = 0;
   bit chk_en   = 1'b0;

   time_set_ctrl #(
      .TIMEOUT_CYCLES(TIMEOUT),
      .HOUR_MAX(HMAX),
      .MS_MAX(MSMAX)
   ) dut (
      .slowclk(slowclk),
      .reset(reset),
      .btn_mode(btn_mode),
      .btn_inc(btn_inc),
      .btn_dec(btn_dec),
      .cur_h(cur_h),
      .cur_m(cur_m),
      .cur_s(cur_s),
      .h_set(h_set),
      .m_set(m_set),
      .s_set(s_set),
      .load(load),
      .field(field),
      .busy(busy)
   );

   always #5 slowclk = ~slowclk;

   // ---------------- behavioural model ----------------
   // md_st: 0 idle, 1 hour, 2 minute, 3 second, 4 commit
   int md_st = 0, md_h = 0, md_m = 0, md_s = 0, md_idle = 0;
   // button samples at the last three edges; -1 = not sampled since reset
   int hm[3] = '{-1, -1, -1};
   int hi[3] = '{-1, -1, -1};
   int hd[3] = '{-1, -1, -1};
   bit e_mode, e_inc, e_dec;

   function automatic int step(input int v, input int vmax, input bit up, input bit dn);
      if (up && !dn) return (v >= vmax) ? 0 : v + 1;
      if (dn && !up) return (v == 0) ? vmax : v - 1;
      return v;
   endfunction

   always @(posedge slowclk or negedge reset) begin
      if (!reset) begin
         md_st = 0; md_h = 0; md_m = 0; md_s = 0; md_idle = 0;
         for (int i = 0; i < 3; i++) begin
            hm[i] = -1; hi[i] = -1; hd[i] = -1;
         end
      end else begin
         // a button rise sampled two edges ago is acted on at this edge
         e_mode = (hm[1] == 1) && (hm[2] == 0);
         e_inc  = (hi[1] == 1) && (hi[2] == 0);
         e_dec  = (hd[1] == 1) && (hd[2] == 0);
         hm[2] = hm[1]; hm[1] = hm[0]; hm[0] = int'(btn_mode);
         hi[2] = hi[1]; hi[1] = hi[0]; hi[0] = int'(btn_inc);
         hd[2] = hd[1]; hd[1] = hd[0]; hd[0] = int'(btn_dec);
         case (md_st)
            0: if (e_mode) begin
                  md_h = int'(cur_h); md_m = int'(cur_m); md_s = int'(cur_s);
                  md_st = 1; md_idle = 0;
               end
            1, 2, 3: begin
               if (e_mode) begin
                  md_st = md_st + 1; md_idle = 0;
               end else if (e_inc || e_dec) begin
                  md_idle = 0;
                  if (md_st == 1) md_h = step(md_h, HMAX, e_inc, e_dec);
                  else if (md_st == 2) md_m = step(md_m, MSMAX, e_inc, e_dec);
                  else md_s = step(md_s, MSMAX, e_inc, e_dec);
               end else begin
                  md_idle = md_idle + 1;
                  if (md_idle >= TIMEOUT) md_st = 0;
               end
            end
            default: md_st = 0;
         endcase
      end
   end

   // ---------------- per-cycle compare against the model ----------------
   logic [4:0] e_h;
   logic [5:0] e_m, e_s;
   logic [1:0] e_field;
   logic       e_load, e_busy;
   int load_seen = 0, ld_h = 0, ld_m = 0, ld_s = 0;

   always @(negedge slowclk) begin
      if (chk_en) begin
         e_h     = md_h[4:0];
         e_m     = md_m[5:0];
         e_s     = md_s[5:0];
         e_field = (md_st >= 1 && md_st <= 3) ? md_st[1:0] : 2'b00;
         e_busy  = (md_st != 0);
         e_load  = (md_st == 4);
         n_checks++;
         if ({h_set, m_set, s_set, load, field, busy} !== {e_h, e_m, e_s, e_load, e_field, e_busy}) begin
            n_err++;
            $display("FAIL model_cycle t=%0t: got h=%0d m=%0d s=%0d load=%b field=%b busy=%b, need h=%0d m=%0d s=%0d load=%b field=%b busy=%b",
                     $time, h_set, m_set, s_set, load, field, busy, e_h, e_m, e_s, e_load, e_field, e_busy);
         end
         if (load === 1'b1) begin
            load_seen++;
            ld_h = int'(h_set); ld_m = int'(m_set); ld_s = int'(s_set);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic lit(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, need %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge slowclk);
         #3;
      end
   endtask

   task automatic press(input bit pm, input bit pi, input bit pd);
      btn_mode = pm; btn_inc = pi; btn_dec = pd;
      cyc(1);
      btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
      cyc(3);
   endtask

   task automatic set_cur(input int h, input int m, input int s);
      cur_h = 5'(h); cur_m = 6'(m); cur_s = 6'(s);
   endtask

   initial begin
      // reset state
      set_cur(12, 34, 56);
      cyc(3);
      chk_en = 1'b1;
      lit("rst_h", int'(h_set), 0);
      lit("rst_field", int'(field), 0);
      lit("rst_busy", int'(busy), 0);
      lit("rst_load", int'(load), 0);
      reset = 1'b1;
      cyc(4);

      // seed from running time
      press(1, 0, 0);
      lit("seed_field", int'(field), 1);
      lit("seed_h", int'(h_set), 12);
      lit("seed_m", int'(m_set), 34);
      lit("seed_s", int'(s_set), 56);
      lit("seed_busy", int'(busy), 1);
      lit("seed_load", int'(load), 0);

      // full edit and commit
      repeat (3) press(0, 1, 0);
      lit("edit_h15", int'(h_set), 15);
      press(1, 0, 0);
      repeat (35) press(0, 0, 1);
      lit("edit_m59", int'(m_set), 59);
      press(1, 0, 0);
      press(0, 1, 0);
      lit("edit_s57", int'(s_set), 57);
      press(1, 0, 0);
      lit("commit_count", load_seen, 1);
      lit("commit_h", ld_h, 15);
      lit("commit_m", ld_m, 59);
      lit("commit_s", ld_s, 57);
      lit("commit_field", int'(field), 0);

      // wrap rules
      set_cur(23, 0, 59);
      press(1, 0, 0);
      press(0, 1, 0);
      lit("wrap_h_up", int'(h_set), 0);
      press(0, 0, 1);
      lit("wrap_h_dn", int'(h_set), 23);
      press(0, 1, 0);
      press(1, 0, 0);
      press(0, 0, 1);
      lit("wrap_m_dn", int'(m_set), 59);
      press(1, 0, 0);
      press(0, 1, 0);
      lit("wrap_s_up", int'(s_set), 0);
      press(1, 0, 0);
      lit("wrap_commit_count", load_seen, 2);
      lit("wrap_commit_h", ld_h, 0);

      // out-of-range seeds
      set_cur(30, 62, 61);
      press(1, 0, 0);
      press(0, 0, 1);
      lit("oor_h_dn", int'(h_set), 29);
      press(1, 0, 0);
      press(0, 1, 0);
      lit("oor_m_up", int'(m_set), 0);
      press(1, 0, 0);
      press(0, 0, 1);
      lit("oor_s_dn", int'(s_set), 60);
      press(1, 0, 0);
      lit("oor_commit_count", load_seen, 3);

      // simultaneous events and timeout refresh
      set_cur(10, 20, 30);
      press(1, 0, 0);
      press(1, 1, 0);
      lit("mode_inc_field", int'(field), 2);
      lit("mode_inc_h", int'(h_set), 10);
      cyc(20);
      press(0, 1, 1);
      lit("incdec_m", int'(m_set), 20);
      cyc(20);
      lit("refresh_field", int'(field), 2);
      cyc(12);
      lit("refresh_expired_field", int'(field), 0);
      lit("refresh_expired_busy", int'(busy), 0);
      lit("refresh_expired_m", int'(m_set), 20);

      // exact timeout boundary
      set_cur(1, 2, 3);
      press(1, 0, 0);
      cyc(28);
      lit("tmo_before_field", int'(field), 1);
      cyc(1);
      lit("tmo_after_field", int'(field), 0);
      lit("tmo_after_busy", int'(busy), 0);
      lit("tmo_keep_h", int'(h_set), 1);
      lit("tmo_no_load", load_seen, 3);

      // reset mid-edit with buttons held through release
      set_cur(5, 6, 7);
      repeat (3) press(1, 0, 0);
      lit("pre_rst_field", int'(field), 3);
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      reset    = 1'b0;
      #1;
      lit("async_rst_h", int'(h_set), 0);
      lit("async_rst_m", int'(m_set), 0);
      lit("async_rst_s", int'(s_set), 0);
      lit("async_rst_field", int'(field), 0);
      lit("async_rst_busy", int'(busy), 0);
      cyc(3);
      reset = 1'b1;
      cyc(8);
      lit("held_field", int'(field), 0);
      lit("held_busy", int'(busy), 0);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      cyc(3);
      lit("rst_no_load", load_seen, 3);
      press(1, 0, 0);
      lit("post_rst_field", int'(field), 1);
      lit("post_rst_h", int'(h_set), 5);
      repeat (3) press(1, 0, 0);
      lit("final_count", load_seen, 4);
      lit("final_s", ld_s, 7);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
